// File: rtl/memacc_pkg.sv
// Shared types and helpers for the memory-access stage.
// Size encodings, FSM states, load lane select and extension.
package memacc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Shift the addressed lane down to bit 0.
  function automatic logic [31:0] laneSel(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  a
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      (sz == SZ_BYTE): r = d >> {a, 3'b000};
      (sz == SZ_HALF): r = d >> {a[1], 4'b0000};
      default:         r = d;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend a lane already at bit 0.
  function automatic logic [31:0] extend(
    input logic [31:0] r,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [31:0] v;
    v = r;
    unique case (1'b1)
      (sz == SZ_BYTE):
        v = {{24{r[7] & ~uns}}, r[7:0]};
      (sz == SZ_HALF):
        v = {{16{r[15] & ~uns}}, r[15:0]};
      default:
        v = r;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/memacc_align.sv
// Store lane replication, byte enables and load extend.
// Purely combinational; shared by store and load paths.
module memacc_align
  import memacc_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] loadData,
  input  logic        loadUnsigned,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] loadValue
);

  logic isByte;
  logic isHalf;

  assign isByte = (size == SZ_BYTE);
  assign isHalf = (size == SZ_HALF);

  // Replicate store data into every lane; enable the addressed ones.
  always_comb begin
    wdata = storeData;
    be    = 4'b1111;
    unique case (1'b1)
      isByte: begin
        wdata = {4{storeData[7:0]}};
        be    = 4'b0001 << addrLo;
      end
      isHalf: begin
        wdata = {2{storeData[15:0]}};
        be    = addrLo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign loadValue = extend(
    laneSel(loadData, size, addrLo),
    size, loadUnsigned);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack data memory port, stall, MEM/WB regs.
// Optional misalignment trap: define MEMACC_MISALIGN_TRAP_EN.
module mem_access_stage
  import memacc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNTW    = $clog2(TIMEOUT + 1)
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        MEMinMemRead,
  input  logic        MEMinMemWrite,
  input  logic        MEMinMemtoReg,
  input  logic        MEMinRegWrite,
  input  logic        MEMinlwusig,
  input  logic        MEMinANDLINK,
  input  logic [1:0]  MEMinSIZE,
  input  logic [31:0] MEMinPCadd,
  input  logic [31:0] MEMinALUans,
  input  logic [31:0] MEMinforb,
  input  logic [4:0]  MEMinREGISTER,
  output logic        DMEMreq,
  output logic        DMEMwe,
  output logic [31:0] DMEMaddr,
  output logic [31:0] DMEMwdata,
  output logic [3:0]  DMEMbe,
  input  logic [31:0] DMEMrdata,
  input  logic        DMEMack,
  output logic        STALL,
  output logic        BUSERR,
  output logic        MEM_WBoutRegWrite,
  output logic [4:0]  MEM_WBoutREGISTER,
  output logic [31:0] MEM_WBoutWDATA
`ifdef MEMACC_MISALIGN_TRAP_EN
  ,
  output logic        MISALIGN
`endif
);

  state_t          state;
  state_t          stateNext;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cntNext;
  logic            memRaw;
  logic            misAl;
  logic            memop;
  logic            timeout;
  logic [1:0]      a;
  logic [31:0]     alWdata;
  logic [3:0]      alBe;
  logic [31:0]     ldVal;
  logic [31:0]     wbData;

  assign a      = MEMinALUans[1:0];
  assign memRaw = MEMinMemRead | MEMinMemWrite;

`ifdef MEMACC_MISALIGN_TRAP_EN
  assign misAl = memRaw &
    (((MEMinSIZE == SZ_HALF) & a[0]) |
     (MEMinSIZE[1] & (a != 2'b00)));
`else
  assign misAl = 1'b0;
`endif

  assign memop = memRaw & ~misAl;

  memacc_align uAlign (
    .size         (MEMinSIZE),
    .addrLo       (a),
    .storeData    (MEMinforb),
    .loadData     (DMEMrdata),
    .loadUnsigned (MEMinlwusig),
    .wdata        (alWdata),
    .be           (alBe),
    .loadValue    (ldVal)
  );

  // State and wait-counter registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state; abort when the counter reaches TIMEOUT this cycle.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop && !DMEMack) begin
          stateNext = BUSY;
          cntNext   = '0;
        end
      end
      BUSY: begin
        cntNext = cnt + 1'b1;
        if (!memop || DMEMack) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cntNext == CNTW'(TIMEOUT)) begin
          timeout   = 1'b1;
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Memory port; everything drops while reset is held.
  always_comb begin
    DMEMreq   = RESET & memop;
    DMEMwe    = RESET & memop & MEMinMemWrite;
    DMEMbe    = (RESET & memop) ? alBe : 4'b0000;
    DMEMaddr  = RESET ? {MEMinALUans[31:2], 2'b00} : '0;
    DMEMwdata = RESET ? alWdata : '0;
    STALL     = RESET & memop & ~DMEMack & ~timeout;
  end

  // Write-back value select: link, load, or ALU result.
  always_comb begin
    if (MEMinANDLINK)
      wbData = MEMinPCadd;
    else if (MEMinMemtoReg)
      wbData = ldVal;
    else
      wbData = MEMinALUans;
  end

  // MEM/WB register; a bubble is loaded while stalled.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      MEM_WBoutRegWrite <= 1'b0;
      MEM_WBoutREGISTER <= '0;
      MEM_WBoutWDATA    <= '0;
      BUSERR            <= 1'b0;
    end else begin
      BUSERR <= timeout;
      if (STALL) begin
        MEM_WBoutRegWrite <= 1'b0;
        MEM_WBoutREGISTER <= '0;
        MEM_WBoutWDATA    <= '0;
      end else begin
        MEM_WBoutRegWrite <=
          MEMinRegWrite & ~timeout & ~misAl;
        MEM_WBoutREGISTER <= MEMinREGISTER;
        MEM_WBoutWDATA    <= wbData;
      end
    end
  end

`ifdef MEMACC_MISALIGN_TRAP_EN
  // One-cycle registered pulse for a trapped access.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      MISALIGN <= 1'b0;
    else
      MISALIGN <= misAl;
  end
`endif

endmodule
